// File: rtl/if_fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_fetch_stage_pkg;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic        epoch;
  } fetch_tag_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/response port and the fetch-to-decode port.
interface if_fetch_stage_if;

  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;

  logic        if_id_valid_inst;
  logic        if_id_ready;
  logic [31:0] if_id_PC;
  logic [31:0] if_id_NPC;
  logic [31:0] if_id_IR;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_resp_valid, imem_resp_data,
    output if_id_valid_inst, if_id_PC, if_id_NPC, if_id_IR,
    input  if_id_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_resp_valid, imem_resp_data,
    input  if_id_valid_inst, if_id_PC, if_id_NPC, if_id_IR,
    output if_id_ready
  );

endinterface

// File: rtl/if_fetch_stage_fifo.sv
// Synchronous FIFO with flush; DEPTH must be a power of two so pointers wrap naturally.
module fetch_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));
  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;

  // A push into a full FIFO is accepted only when the head leaves in the same cycle.
  always_comb begin
    do_pop   = pop & ~empty;
    do_push  = push & (~full | do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: credit-limited word fetch, in-order response buffering,
// and epoch-based squashing of younger fetches on an EX redirect.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ex_take_branch_in,
  input  logic [31:0]           ex_target_PC_in,
  if_fetch_stage_if.master      bus
);

  localparam int              CNT_W   = $clog2(BUF_DEPTH) + 1;
  localparam logic [CNT_W:0]  CREDITS = (CNT_W+1)'(BUF_DEPTH);

  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic             epoch_q, epoch_d;
  fetch_tag_t       tag_in, tag_out;
  fetch_entry_t     ent_in, ent_out;
  logic             tag_full, tag_empty, buf_full, buf_empty;
  logic [CNT_W-1:0] outstanding, buf_count;
  logic [CNT_W:0]   in_use;
  logic             req_valid, req_fire, resp_take, resp_keep;
  logic             buf_push, buf_pop, out_valid;

  // Every in-flight request owns a buffer slot, so responses can never overflow.
  assign in_use = {1'b0, outstanding} + {1'b0, buf_count};

  always_comb begin
    req_valid  = (in_use < CREDITS) & ~ex_take_branch_in & ~tag_full;
    req_fire   = req_valid & bus.imem_req_ready;
    resp_take  = bus.imem_resp_valid & ~tag_empty;
    resp_keep  = resp_take & (tag_out.epoch == epoch_q) & ~ex_take_branch_in;
    out_valid  = ~buf_empty & ~ex_take_branch_in;
    buf_pop    = out_valid & bus.if_id_ready;
    buf_push   = resp_keep & (~buf_full | buf_pop);
    tag_in     = '{pc: fetch_pc_q, epoch: epoch_q};
    ent_in     = '{pc: tag_out.pc, inst: bus.imem_resp_data};
    fetch_pc_d = fetch_pc_q;
    epoch_d    = epoch_q;
    if (ex_take_branch_in) begin
      fetch_pc_d = ex_target_PC_in & 32'hFFFF_FFFC;
      epoch_d    = ~epoch_q;
    end else if (req_fire) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      epoch_q    <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      epoch_q    <= epoch_d;
    end
  end

  fetch_fifo #(.WIDTH($bits(fetch_tag_t)), .DEPTH(BUF_DEPTH)) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (1'b0),
    .push  (req_fire),
    .din   (tag_in),
    .pop   (resp_take),
    .dout  (tag_out),
    .full  (tag_full),
    .empty (tag_empty),
    .count (outstanding)
  );

  // Redirect flushes the buffer; stale tags stay queued until their responses drain.
  fetch_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(BUF_DEPTH)) u_inst_buf (
    .clk   (clk),
    .rst   (rst),
    .flush (ex_take_branch_in),
    .push  (buf_push),
    .din   (ent_in),
    .pop   (buf_pop),
    .dout  (ent_out),
    .full  (buf_full),
    .empty (buf_empty),
    .count (buf_count)
  );

  assign bus.imem_req_valid   = req_valid;
  assign bus.imem_req_addr    = fetch_pc_q;
  assign bus.if_id_valid_inst = out_valid;
  assign bus.if_id_PC         = out_valid ? ent_out.pc          : 32'h0;
  assign bus.if_id_NPC        = out_valid ? ent_out.pc + 32'd4  : 32'h0;
  assign bus.if_id_IR         = out_valid ? ent_out.inst        : NOP_INST;

  a_credit_bound: assert property (@(posedge clk) disable iff (!rst) in_use <= CREDITS);

endmodule
